icache_fetch_mem_queue: RTL and testbench

- Sits directly downstream of the icache memory adapter and serves its fetch_mem request/ack channel.
- Buffers fetch requests and issues them in order to a fixed-latency instruction-memory read port.
- Carries each request's opaque tag (opcode+MSHR id+txnid) alongside it; returns line data plus tag through a credit-protected response FIFO.
- Never drops a response under ack backpressure.

---
 rtl/icache_fetch_mem_queue_if.sv | 28 ++
 rtl/icache_fetch_mem_queue.sv | 217 +++++++++++++++++++++
 tb/tb_icache_fetch_mem_queue.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_fetch_mem_queue_if.sv
// Fetch-memory request/ack channel between the icache memory adapter (master)
// and icache_fetch_mem_queue (slave).
//   fetch_mem_req_*  : request valid/ready handshake carrying address and opaque tag
//   fetch_mem_ack_*  : response valid/ready handshake carrying line data and tag
interface icache_fetch_mem_queue_if #(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned FETCH_DATA_WIDTH = 256,
  parameter int unsigned TAG_WIDTH        = 12
) ();
  logic                        fetch_mem_req_vld;
  logic                        fetch_mem_req_rdy;
  logic [ADDR_WIDTH-1:0]       fetch_mem_req_addr;
  logic [TAG_WIDTH-1:0]        fetch_mem_req_entry_id;
  logic                        fetch_mem_ack_vld;
  logic                        fetch_mem_ack_rdy;
  logic [FETCH_DATA_WIDTH-1:0] fetch_mem_ack_data;
  logic [TAG_WIDTH-1:0]        fetch_mem_ack_entry_id;

  modport master (
    output fetch_mem_req_vld, fetch_mem_req_addr, fetch_mem_req_entry_id, fetch_mem_ack_rdy,
    input  fetch_mem_req_rdy, fetch_mem_ack_vld, fetch_mem_ack_data, fetch_mem_ack_entry_id
  );

  modport slave (
    input  fetch_mem_req_vld, fetch_mem_req_addr, fetch_mem_req_entry_id, fetch_mem_ack_rdy,
    output fetch_mem_req_rdy, fetch_mem_ack_vld, fetch_mem_ack_data, fetch_mem_ack_entry_id
  );
endinterface

// File: rtl/icache_fetch_mem_queue.sv
// Fetch request queue in front of a fixed-latency instruction memory.
// Requests are buffered, issued in order to the memory read port, tracked through a
// MEM_LAT-deep in-flight pipeline together with their opaque tag, and returned through
// a credit-protected response FIFO so no response is ever dropped under backpressure.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   fetch_mem    : slave side of the request/ack channel (icache_fetch_mem_queue_if)
//   mem_rd_en    : one-cycle read strobe per issued request
//   mem_rd_addr  : line-aligned read address
//   mem_rd_data  : read data, valid exactly MEM_LAT cycles after mem_rd_en
//   idle         : nothing queued, in flight or buffered
//   perf_*       : saturating event counters, present only with
//                  ICACHE_FETCH_MEM_QUEUE_PERF_EN defined
module icache_fetch_mem_queue #(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned FETCH_DATA_WIDTH = 256,
  parameter int unsigned TAG_WIDTH        = 12,
  parameter int unsigned REQ_DEPTH        = 4,
  parameter int unsigned RSP_DEPTH        = 4,
  parameter int unsigned MEM_LAT          = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  icache_fetch_mem_queue_if.slave     fetch_mem,
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
  input  logic [FETCH_DATA_WIDTH-1:0] mem_rd_data,
  output logic                        idle
`ifdef ICACHE_FETCH_MEM_QUEUE_PERF_EN
  ,
  output logic [31:0]                 perf_req_cnt,
  output logic [31:0]                 perf_credit_stall_cnt,
  output logic [31:0]                 perf_ack_stall_cnt
`endif
);

  localparam int unsigned REQ_AW = $clog2(REQ_DEPTH);
  localparam int unsigned RSP_AW = $clog2(RSP_DEPTH);
  localparam int unsigned OFFS_W = $clog2(FETCH_DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'((64'd1 << OFFS_W) - 64'd1);

  // Request FIFO
  logic [ADDR_WIDTH-1:0] req_addr_q [REQ_DEPTH];
  logic [ADDR_WIDTH-1:0] req_addr_d [REQ_DEPTH];
  logic [TAG_WIDTH-1:0]  req_tag_q  [REQ_DEPTH];
  logic [TAG_WIDTH-1:0]  req_tag_d  [REQ_DEPTH];
  logic [REQ_AW-1:0]     req_wptr_q, req_wptr_d, req_rptr_q, req_rptr_d;
  logic [REQ_AW:0]       req_cnt_q, req_cnt_d;
  logic                  req_push, req_empty, req_full;

  // Issue stage and in-flight pipeline
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic [TAG_WIDTH-1:0]  iss_tag_q, iss_tag_d;
  logic [MEM_LAT-1:0]    pipe_vld_q, pipe_vld_d;
  logic [TAG_WIDTH-1:0]  pipe_tag_q [MEM_LAT];
  logic [TAG_WIDTH-1:0]  pipe_tag_d [MEM_LAT];
  logic [31:0]           inflight;
  logic                  credit_ok, issue;

  // Response FIFO
  logic [FETCH_DATA_WIDTH-1:0] rsp_data_q [RSP_DEPTH];
  logic [FETCH_DATA_WIDTH-1:0] rsp_data_d [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]        rsp_tag_q  [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]        rsp_tag_d  [RSP_DEPTH];
  logic [RSP_AW-1:0]           rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
  logic [RSP_AW:0]             rsp_cnt_q, rsp_cnt_d;
  logic                        rsp_push, rsp_pop, rsp_empty;

  assign req_empty = (req_cnt_q == '0);
  assign req_full  = (req_cnt_q == (REQ_AW+1)'(REQ_DEPTH));
  assign req_push  = fetch_mem.fetch_mem_req_vld && !req_full;

  assign rsp_empty = (rsp_cnt_q == '0);
  assign rsp_push  = pipe_vld_q[MEM_LAT-1];
  assign rsp_pop   = !rsp_empty && fetch_mem.fetch_mem_ack_rdy;

  // The issue register holds a credit too: a read strobed this cycle has not yet
  // reached pipeline stage 0 but its response still needs a FIFO slot.
  always_comb begin
    inflight = 32'(mem_rd_en_q);
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + 32'(pipe_vld_q[i]);
    end
  end

  assign credit_ok = (32'(rsp_cnt_q) + inflight) < RSP_DEPTH;
  assign issue     = !req_empty && credit_ok;

  always_comb begin
    req_addr_d = req_addr_q;
    req_tag_d  = req_tag_q;
    req_wptr_d = req_wptr_q;
    req_rptr_d = req_rptr_q;
    if (req_push) begin
      req_addr_d[req_wptr_q] = fetch_mem.fetch_mem_req_addr;
      req_tag_d[req_wptr_q]  = fetch_mem.fetch_mem_req_entry_id;
      req_wptr_d             = req_wptr_q + REQ_AW'(1);
    end
    if (issue) begin
      req_rptr_d = req_rptr_q + REQ_AW'(1);
    end
    req_cnt_d = req_cnt_q + (REQ_AW+1)'(req_push) - (REQ_AW+1)'(issue);

    mem_rd_en_d   = issue;
    mem_rd_addr_d = mem_rd_addr_q;
    iss_tag_d     = iss_tag_q;
    if (issue) begin
      mem_rd_addr_d = req_addr_q[req_rptr_q] & AlignMask;
      iss_tag_d     = req_tag_q[req_rptr_q];
    end

    pipe_vld_d[0] = mem_rd_en_q;
    pipe_tag_d[0] = iss_tag_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end

    // Capture is unconditional; the credit check guarantees a free slot.
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_wptr_d = rsp_wptr_q;
    rsp_rptr_d = rsp_rptr_q;
    if (rsp_push) begin
      rsp_data_d[rsp_wptr_q] = mem_rd_data;
      rsp_tag_d[rsp_wptr_q]  = pipe_tag_q[MEM_LAT-1];
      rsp_wptr_d             = rsp_wptr_q + RSP_AW'(1);
    end
    if (rsp_pop) begin
      rsp_rptr_d = rsp_rptr_q + RSP_AW'(1);
    end
    rsp_cnt_d = rsp_cnt_q + (RSP_AW+1)'(rsp_push) - (RSP_AW+1)'(rsp_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_wptr_q    <= '0;
      req_rptr_q    <= '0;
      req_cnt_q     <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      iss_tag_q     <= '0;
      pipe_vld_q    <= '0;
      rsp_wptr_q    <= '0;
      rsp_rptr_q    <= '0;
      rsp_cnt_q     <= '0;
    end else begin
      req_wptr_q    <= req_wptr_d;
      req_rptr_q    <= req_rptr_d;
      req_cnt_q     <= req_cnt_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      iss_tag_q     <= iss_tag_d;
      pipe_vld_q    <= pipe_vld_d;
      rsp_wptr_q    <= rsp_wptr_d;
      rsp_rptr_q    <= rsp_rptr_d;
      rsp_cnt_q     <= rsp_cnt_d;
    end
  end

  // Storage only; validity is tracked by the reset pointers/valids above.
  always_ff @(posedge clk) begin
    req_addr_q <= req_addr_d;
    req_tag_q  <= req_tag_d;
    pipe_tag_q <= pipe_tag_d;
    rsp_data_q <= rsp_data_d;
    rsp_tag_q  <= rsp_tag_d;
  end

  assign fetch_mem.fetch_mem_req_rdy      = !req_full;
  assign fetch_mem.fetch_mem_ack_vld      = !rsp_empty;
  assign fetch_mem.fetch_mem_ack_data     = rsp_empty ? '0 : rsp_data_q[rsp_rptr_q];
  assign fetch_mem.fetch_mem_ack_entry_id = rsp_empty ? '0 : rsp_tag_q[rsp_rptr_q];
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign idle        = req_empty && (inflight == 32'd0) && rsp_empty;

`ifdef ICACHE_FETCH_MEM_QUEUE_PERF_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_credit_q, perf_credit_d;
  logic [31:0] perf_ack_q, perf_ack_d;

  always_comb begin
    perf_req_d    = perf_req_q;
    perf_credit_d = perf_credit_q;
    perf_ack_d    = perf_ack_q;
    if (req_push && (perf_req_q != '1)) begin
      perf_req_d = perf_req_q + 32'd1;
    end
    if (!req_empty && !credit_ok && (perf_credit_q != '1)) begin
      perf_credit_d = perf_credit_q + 32'd1;
    end
    if (!rsp_empty && !fetch_mem.fetch_mem_ack_rdy && (perf_ack_q != '1)) begin
      perf_ack_d = perf_ack_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_req_q    <= '0;
      perf_credit_q <= '0;
      perf_ack_q    <= '0;
    end else begin
      perf_req_q    <= perf_req_d;
      perf_credit_q <= perf_credit_d;
      perf_ack_q    <= perf_ack_d;
    end
  end

  assign perf_req_cnt          = perf_req_q;
  assign perf_credit_stall_cnt = perf_credit_q;
  assign perf_ack_stall_cnt    = perf_ack_q;
`endif

endmodule

// File: tb/tb_icache_fetch_mem_queue.sv
// Directed, table-driven bench for icache_fetch_mem_queue (default parameters:
// 32-bit address, 256-bit lines, 12-bit tags, 4/4 FIFO depth, MEM_LAT=2).
module tb_icache_fetch_mem_queue;

  logic         clk;
  logic         rst;
  logic         mem_rd_en;
  logic [31:0]  mem_rd_addr;
  logic [255:0] mem_rd_data;
  logic         idle;
`ifdef ICACHE_FETCH_MEM_QUEUE_PERF_EN
  logic [31:0]  perf_req_cnt;
  logic [31:0]  perf_credit_stall_cnt;
  logic [31:0]  perf_ack_stall_cnt;
`endif

  icache_fetch_mem_queue_if #(
    .ADDR_WIDTH      (32),
    .FETCH_DATA_WIDTH(256),
    .TAG_WIDTH       (12)
  ) fm_if ();

  icache_fetch_mem_queue #(
    .ADDR_WIDTH      (32),
    .FETCH_DATA_WIDTH(256),
    .TAG_WIDTH       (12),
    .REQ_DEPTH       (4),
    .RSP_DEPTH       (4),
    .MEM_LAT         (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_mem  (fm_if.slave),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .idle       (idle)
`ifdef ICACHE_FETCH_MEM_QUEUE_PERF_EN
    ,
    .perf_req_cnt         (perf_req_cnt),
    .perf_credit_stall_cnt(perf_credit_stall_cnt),
    .perf_ack_stall_cnt   (perf_ack_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = a + 32'(i) * 32'h0101_0101;
    return d;
  endfunction

  // Memory: data for a read strobed in cycle C is presented during cycle C+2.
  logic [1:0]  mvld = 2'b00;
  logic [31:0] maddr0 = '0;
  logic [31:0] maddr1 = '0;
  always @(posedge clk) begin
    mvld   <= {mvld[0], mem_rd_en};
    maddr0 <= mem_rd_addr;
    maddr1 <= maddr0;
  end
  assign mem_rd_data = mvld[1] ? line_of(maddr1) : {8{32'hDEAD_BEEF}};

  // Monitor: record handshakes mid-cycle, when everything is stable.
  logic [11:0]  ack_tag_q  [$];
  logic [255:0] ack_data_q [$];
  logic [31:0]  iss_addr_q [$];
  int n_iss = 0;
  int n_ack = 0;
  int vld_cycles = 0;
  int max_out = 0;
  always @(negedge clk) begin
    if (mem_rd_en) begin
      iss_addr_q.push_back(mem_rd_addr);
      n_iss <= n_iss + 1;
    end
    if (fm_if.fetch_mem_ack_vld && fm_if.fetch_mem_ack_rdy) begin
      ack_tag_q.push_back(fm_if.fetch_mem_ack_entry_id);
      ack_data_q.push_back(fm_if.fetch_mem_ack_data);
      n_ack <= n_ack + 1;
    end
    if (fm_if.fetch_mem_ack_vld) vld_cycles <= vld_cycles + 1;
    if (n_iss - n_ack > max_out) max_out <= n_iss - n_ack;
  end

  typedef struct {
    logic [31:0] addr;
    logic [11:0] tag;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs [8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [11:0] t);
    int n = 0;
    while (!fm_if.fetch_mem_req_rdy && n < 50) begin
      step();
      n++;
    end
    if (!fm_if.fetch_mem_req_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: req_rdy stuck at 0 for tag %0h", t);
    end
    fm_if.fetch_mem_req_vld      = 1'b1;
    fm_if.fetch_mem_req_addr     = a;
    fm_if.fetch_mem_req_entry_id = t;
    step();
    fm_if.fetch_mem_req_vld = 1'b0;
  endtask

  task automatic wait_acks(input int n, input int base, input string name);
    int k = 0;
    while (ack_tag_q.size() < base + n && k < 200) begin
      step();
      k++;
    end
    if (ack_tag_q.size() < base + n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d acks, required %0d", name, ack_tag_q.size() - base, n);
    end
  endtask

  task automatic check_ack(input string name, input int idx, input logic [11:0] tag,
                           input logic [255:0] data);
    if (idx < ack_tag_q.size()) begin
      check({name, "_tag"}, 256'(ack_tag_q[idx]), 256'(tag));
      check({name, "_data"}, ack_data_q[idx], data);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: ack %0d missing, required tag %0h", name, idx, tag);
    end
  endtask

  initial begin
    int base_a, base_i, v0, k;

    vecs[0] = '{32'h0000_1004, 12'h001, 32'h0000_1000};
    vecs[1] = '{32'h0000_203F, 12'h002, 32'h0000_2020};
    vecs[2] = '{32'h0000_0020, 12'h003, 32'h0000_0020};
    vecs[3] = '{32'hFFFF_FFFF, 12'h004, 32'hFFFF_FFE0};
    vecs[4] = '{32'h1234_5678, 12'h005, 32'h1234_5660};
    vecs[5] = '{32'h0000_001F, 12'h006, 32'h0000_0000};
    vecs[6] = '{32'h8000_0041, 12'h007, 32'h8000_0040};
    vecs[7] = '{32'h0ABC_DEF0, 12'h008, 32'h0ABC_DEE0};

    rst = 1'b1;
    fm_if.fetch_mem_req_vld      = 1'b0;
    fm_if.fetch_mem_req_addr     = '0;
    fm_if.fetch_mem_req_entry_id = '0;
    fm_if.fetch_mem_ack_rdy      = 1'b1;
    step();
    step();

    // Reset state
    check("rst_ack_vld", 256'(fm_if.fetch_mem_ack_vld), 256'(0));
    check("rst_mem_rd_en", 256'(mem_rd_en), 256'(0));
    check("rst_mem_rd_addr", 256'(mem_rd_addr), 256'(0));
    check("rst_ack_data", fm_if.fetch_mem_ack_data, 256'(0));
    check("rst_ack_tag", 256'(fm_if.fetch_mem_ack_entry_id), 256'(0));
    check("rst_req_rdy", 256'(fm_if.fetch_mem_req_rdy), 256'(1));
    check("rst_idle", 256'(idle), 256'(1));
    rst = 1'b0;
    step();

    // Single request: latency profile
    base_a = ack_tag_q.size();
    push(32'h0000_1004, 12'h0A5);                           // now in cycle T
    check("single_T_idle", 256'(idle), 256'(0));
    step();                                                 // T+1
    check("single_T1_rd_en", 256'(mem_rd_en), 256'(1));
    check("single_T1_rd_addr", 256'(mem_rd_addr), 256'(32'h0000_1000));
    step();                                                 // T+2
    check("single_T2_rd_en", 256'(mem_rd_en), 256'(0));
    step();                                                 // T+3
    check("single_T3_ack_vld", 256'(fm_if.fetch_mem_ack_vld), 256'(0));
    step();                                                 // T+4
    check("single_T4_ack_vld", 256'(fm_if.fetch_mem_ack_vld), 256'(1));
    check("single_T4_ack_tag", 256'(fm_if.fetch_mem_ack_entry_id), 256'(12'h0A5));
    check("single_T4_ack_data", fm_if.fetch_mem_ack_data, line_of(32'h0000_1000));
    step();                                                 // T+5
    check("single_T5_idle", 256'(idle), 256'(1));
    check("single_T5_ack_vld", 256'(fm_if.fetch_mem_ack_vld), 256'(0));
    check("single_ack_count", 256'(ack_tag_q.size() - base_a), 256'(1));

    // Table: back-to-back requests with ack_rdy=1
    base_a = ack_tag_q.size();
    base_i = iss_addr_q.size();
    for (int i = 0; i < 8; i++) push(vecs[i].addr, vecs[i].tag);
    wait_acks(8, base_a, "b2b");
    for (int i = 0; i < 8; i++) begin
      check_ack($sformatf("b2b_%0d", i), base_a + i, vecs[i].tag, line_of(vecs[i].exp_addr));
      if (base_i + i < iss_addr_q.size())
        check($sformatf("b2b_rd_addr_%0d", i), 256'(iss_addr_q[base_i + i]),
              256'(vecs[i].exp_addr));
    end
    repeat (3) step();
    check("b2b_idle", 256'(idle), 256'(1));

    // Ack backpressure: credits stop issue at 4, req FIFO fills behind
    fm_if.fetch_mem_ack_rdy = 1'b0;
    base_a = ack_tag_q.size();
    base_i = iss_addr_q.size();
    for (int i = 0; i < 8; i++) push(vecs[i].addr, vecs[i].tag);
    repeat (10) step();
    check("bp_issue_count", 256'(iss_addr_q.size() - base_i), 256'(4));
    check("bp_req_rdy", 256'(fm_if.fetch_mem_req_rdy), 256'(0));
    check("bp_ack_vld", 256'(fm_if.fetch_mem_ack_vld), 256'(1));
    check("bp_head_tag", 256'(fm_if.fetch_mem_ack_entry_id), 256'(vecs[0].tag));
    repeat (3) step();
    check("bp_hold_tag", 256'(fm_if.fetch_mem_ack_entry_id), 256'(vecs[0].tag));
    check("bp_hold_data", fm_if.fetch_mem_ack_data, line_of(vecs[0].exp_addr));

    // One pop frees one credit; the resulting capture lands together with a second pop
    fm_if.fetch_mem_ack_rdy = 1'b1;
    step();
    fm_if.fetch_mem_ack_rdy = 1'b0;
    k = 0;
    while (!mem_rd_en && k < 20) begin
      step();
      k++;
    end
    check("cap_pop_issue_seen", 256'(mem_rd_en), 256'(1));
    check("cap_pop_issue_addr", 256'(mem_rd_addr), 256'(vecs[4].exp_addr));
    step();
    step();
    fm_if.fetch_mem_ack_rdy = 1'b1;
    step();                                                 // capture + pop edge
    fm_if.fetch_mem_ack_rdy = 1'b0;
    check("cap_pop_ack_vld", 256'(fm_if.fetch_mem_ack_vld), 256'(1));
    check("cap_pop_head_tag", 256'(fm_if.fetch_mem_ack_entry_id), 256'(vecs[2].tag));
    v0 = iss_addr_q.size();
    repeat (6) step();
    // Three entries held, so exactly one further credit exists.
    check("cap_pop_one_credit", 256'(iss_addr_q.size() - v0), 256'(1));
    fm_if.fetch_mem_ack_rdy = 1'b1;
    wait_acks(8, base_a, "bp_drain");
    for (int i = 0; i < 8; i++)
      check_ack($sformatf("bp_%0d", i), base_a + i, vecs[i].tag, line_of(vecs[i].exp_addr));
    check("bp_total_issue", 256'(iss_addr_q.size() - base_i), 256'(8));
    repeat (3) step();
    check("max_outstanding_le4", 256'(max_out <= 4), 256'(1));

    // Reset with two buffered and two in flight
    fm_if.fetch_mem_ack_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h0000_3000 + 32'(i) * 32'h40, 12'h101 + 12'(i));
    step();
    step();
    check("pre_rst_ack_vld", 256'(fm_if.fetch_mem_ack_vld), 256'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ack_vld", 256'(fm_if.fetch_mem_ack_vld), 256'(0));
    check("mid_rst_idle", 256'(idle), 256'(1));
    check("mid_rst_req_rdy", 256'(fm_if.fetch_mem_req_rdy), 256'(1));
    fm_if.fetch_mem_ack_rdy = 1'b1;
    v0 = vld_cycles;
    repeat (6) step();
    check("mid_rst_no_stale_ack", 256'(vld_cycles - v0), 256'(0));
    base_a = ack_tag_q.size();
    push(32'h0000_2044, 12'h077);
    wait_acks(1, base_a, "post_rst");
    check_ack("post_rst", base_a, 12'h077, line_of(32'h0000_2040));
    repeat (2) step();
    check("post_rst_idle", 256'(idle), 256'(1));

`ifdef ICACHE_FETCH_MEM_QUEUE_PERF_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    fm_if.fetch_mem_ack_rdy = 1'b0;
    base_a = ack_tag_q.size();
    for (int i = 0; i < 5; i++) push(vecs[i].addr, vecs[i].tag);
    k = 0;
    while (!fm_if.fetch_mem_ack_vld && k < 20) begin
      step();
      k++;
    end
    repeat (3) step();
    fm_if.fetch_mem_ack_rdy = 1'b1;
    wait_acks(5, base_a, "perf");
    check("perf_req_cnt", 256'(perf_req_cnt), 256'(5));
    check("perf_ack_stall_cnt", 256'(perf_ack_stall_cnt), 256'(3));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
